// File: rtl/muldiv_arbiter_if.sv
// Bundle of requester-side and mul/div-unit-side signals for muldiv_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface muldiv_arbiter_if #(
    parameter int N = 16
);
    logic [1:0]     req_valid_i;
    logic [5:0]     req_op_i;
    logic [2*N-1:0] req_ra_i;
    logic [2*N-1:0] req_rb_i;
    logic [1:0]     req_ready_o;
    logic [1:0]     resp_valid_o;
    logic [N-1:0]   resp_data_o;
    logic           resp_err_o;
    logic           md_valid_o;
    logic [7:0]     md_inst_o;
    logic [N-1:0]   md_ra_o;
    logic [N-1:0]   md_rb_o;
    logic           md_stall_i;
    logic           md_ready_i;
    logic [N-1:0]   md_result_i;

    modport slave (
        input  req_valid_i, req_op_i, req_ra_i, req_rb_i,
        input  md_stall_i, md_ready_i, md_result_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        output md_valid_o, md_inst_o, md_ra_o, md_rb_o
    );

    modport master (
        output req_valid_i, req_op_i, req_ra_i, req_rb_i,
        output md_stall_i, md_ready_i, md_result_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        input  md_valid_o, md_inst_o, md_ra_o, md_rb_o
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// Two-requester round-robin front end for a shared mul/div unit, one operation in flight.
// Define MULDIV_ARB_WDT_EN to add a 63-cycle watchdog on the WAIT state.
module muldiv_arbiter #(
    parameter int N = 16
) (
    input logic             clk_i,
    input logic             rst_ni,
    muldiv_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_ptr;
    logic         r_owner;
    logic [2:0]   r_op;
    logic [N-1:0] r_ra;
    logic [N-1:0] r_rb;
    logic [N-1:0] r_data;
    logic         w_any_req;
    logic         w_grant;
    logic         w_gnt_id;
    logic [2:0]   w_gnt_op;
    logic [N-1:0] w_gnt_ra;
    logic [N-1:0] w_gnt_rb;
    logic         w_timeout;

    function automatic logic [7:0] op_onehot(input logic [2:0] op);
        op_onehot = 8'h01 << op;
    endfunction

    // Requests are masked while reset is held so no accept pulse leaks out.
    assign w_any_req = rst_ni & (|bus.req_valid_i);
    assign w_grant   = (r_state == IDLE) && w_any_req;
    assign w_gnt_op  = w_gnt_id ? bus.req_op_i[5:3]       : bus.req_op_i[2:0];
    assign w_gnt_ra  = w_gnt_id ? bus.req_ra_i[2*N-1:N]   : bus.req_ra_i[N-1:0];
    assign w_gnt_rb  = w_gnt_id ? bus.req_rb_i[2*N-1:N]   : bus.req_rb_i[N-1:0];

    // Round-robin pick: the pointer only matters when both requesters contend.
    always_comb begin
        w_gnt_id = 1'b0;
        if (bus.req_valid_i == 2'b11) begin
            w_gnt_id = r_ptr;
        end else begin
            w_gnt_id = bus.req_valid_i[1];
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        w_next           = r_state;
        bus.req_ready_o  = 2'b00;
        bus.resp_valid_o = 2'b00;
        bus.md_valid_o   = 1'b0;
        bus.md_inst_o    = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next          = ISSUE;
                    bus.req_ready_o = w_gnt_id ? 2'b10 : 2'b01;
                end else begin
                    w_next = IDLE;
                end
            end
            ISSUE: begin
                bus.md_valid_o = 1'b1;
                bus.md_inst_o  = op_onehot(r_op);
                if (!bus.md_stall_i) begin
                    w_next = WAIT;
                end else begin
                    w_next = ISSUE;
                end
            end
            WAIT: begin
                if (bus.md_ready_i || w_timeout) begin
                    w_next = RESP;
                end else begin
                    w_next = WAIT;
                end
            end
            RESP: begin
                bus.resp_valid_o = r_owner ? 2'b10 : 2'b01;
                w_next           = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Grant capture and result capture; a timeout result is forced to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_op    <= 3'd0;
            r_ra    <= {N{1'b0}};
            r_rb    <= {N{1'b0}};
            r_data  <= {N{1'b0}};
        end else begin
            if (w_grant) begin
                r_ptr   <= ~w_gnt_id;
                r_owner <= w_gnt_id;
                r_op    <= w_gnt_op;
                r_ra    <= w_gnt_ra;
                r_rb    <= w_gnt_rb;
            end
            if (r_state == WAIT) begin
                if (bus.md_ready_i) begin
                    r_data <= bus.md_result_i;
                end else if (w_timeout) begin
                    r_data <= {N{1'b0}};
                end
            end
        end
    end

    assign bus.md_ra_o     = r_ra;
    assign bus.md_rb_o     = r_rb;
    assign bus.resp_data_o = r_data;

`ifdef MULDIV_ARB_WDT_EN
    logic [5:0] r_wdt_cnt;
    logic       r_err;

    assign w_timeout = (r_state == WAIT) && (r_wdt_cnt == 6'd63);

    // WAIT-cycle counter, zero on entry to WAIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdt_cnt <= 6'd0;
        end else if (r_state != WAIT) begin
            r_wdt_cnt <= 6'd0;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + 6'd1;
        end
    end

    // A unit result in the expiry cycle wins over the timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if ((r_state == WAIT) && bus.md_ready_i) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign bus.resp_err_o = (r_state == RESP) && r_err;
`else
    assign w_timeout      = 1'b0;
    assign bus.resp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Scoreboard bench for muldiv_arbiter: directed requests, a behavioural mul/div unit,
// and a monitor that checks every accept, issue and response against queued expectations.
module tb_muldiv_arbiter;
    localparam int N = 16;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    muldiv_arbiter_if #(.N(N)) bus ();
    muldiv_arbiter #(.N(N)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
        int          lat;
        int          stamp;
    } resp_t;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  inst;
        logic [15:0] ra;
        logic [15:0] rb;
    } iss_t;

    resp_t rq[$];
    iss_t  iq[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    unit_lat = 1;
    bit    unit_hang = 1'b0;
    logic  unit_rdy = 1'b0;
    logic  spur_rdy = 1'b0;

    assign bus.md_ready_i = unit_rdy | spur_rdy;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference mul/div behaviour (RISC-V M semantics at 16 bits).
    function automatic logic [15:0] md_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa, sb, p, q;
        logic [31:0] ua, ub, up;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        ua = {16'h0000, a};
        ub = {16'h0000, b};
        md_model = 16'h0000;
        case (op)
            3'd0: begin p = sa * sb; md_model = p[15:0]; end
            3'd1: begin p = sa * sb; md_model = p[31:16]; end
            3'd2: begin p = sa * $signed(ub); md_model = p[31:16]; end
            3'd3: begin up = ua * ub; md_model = up[31:16]; end
            3'd4: begin
                if (b == 16'h0000) md_model = 16'hFFFF;
                else if (a == 16'h8000 && b == 16'hFFFF) md_model = a;
                else begin q = sa / sb; md_model = q[15:0]; end
            end
            3'd5: md_model = (b == 16'h0000) ? 16'hFFFF : a / b;
            3'd6: begin
                if (b == 16'h0000) md_model = a;
                else if (a == 16'h8000 && b == 16'hFFFF) md_model = 16'h0000;
                else begin q = sa % sb; md_model = q[15:0]; end
            end
            default: md_model = (b == 16'h0000) ? a : a % b;
        endcase
    endfunction

    // Behavioural unit: checks each taken issue, answers after unit_lat WAIT cycles.
    initial begin
        iss_t e;
        logic [15:0] res;
        bus.md_result_i = 16'hDEAD;
        forever begin
            @(negedge clk_i);
            if (rst_ni && bus.md_valid_o && !bus.md_stall_i) begin
                total++;
                if (iq.size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected inst=%h ra=%h rb=%h", bus.md_inst_o, bus.md_ra_o, bus.md_rb_o);
                end else begin
                    e = iq.pop_front();
                    if (bus.md_inst_o !== e.inst || bus.md_ra_o !== e.ra || bus.md_rb_o !== e.rb) begin
                        bad++;
                        $display("FAIL issue got inst=%h ra=%h rb=%h want inst=%h ra=%h rb=%h",
                                 bus.md_inst_o, bus.md_ra_o, bus.md_rb_o, e.inst, e.ra, e.rb);
                    end
                end
                res = md_model(e.op, bus.md_ra_o, bus.md_rb_o);
                if (!unit_hang) begin
                    @(posedge clk_i); #1;
                    repeat (unit_lat - 1) begin @(posedge clk_i); #1; end
                    unit_rdy = 1'b1;
                    bus.md_result_i = res;
                    @(posedge clk_i); #1;
                    unit_rdy = 1'b0;
                    bus.md_result_i = 16'hDEAD;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response pulse appears.
    initial begin
        resp_t r;
        logic [1:0] exp_v;
        int got_lat;
        forever begin
            @(negedge clk_i);
            if (bus.req_ready_o != 2'b00) begin
                total++;
                if (!$onehot(bus.req_ready_o)) begin
                    bad++;
                    $display("FAIL ready_onehot got=%b", bus.req_ready_o);
                end
            end
            if (bus.resp_valid_o != 2'b00) begin
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected valid=%b data=%h err=%b", bus.resp_valid_o, bus.resp_data_o, bus.resp_err_o);
                end else begin
                    r = rq.pop_front();
                    exp_v = (r.id == 1) ? 2'b10 : 2'b01;
                    got_lat = cyc - r.stamp;
                    if (bus.resp_valid_o !== exp_v || bus.resp_data_o !== r.data || bus.resp_err_o !== r.err ||
                        (r.lat >= 0 && got_lat != r.lat)) begin
                        bad++;
                        $display("FAIL resp got valid=%b data=%h err=%b lat=%0d want valid=%b data=%h err=%b lat=%0d",
                                 bus.resp_valid_o, bus.resp_data_o, bus.resp_err_o, got_lat, exp_v, r.data, r.err, r.lat);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic set_req(input int k, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.req_op_i[3*k +: 3]  = op;
        bus.req_ra_i[16*k +: 16] = a;
        bus.req_rb_i[16*k +: 16] = b;
        bus.req_valid_i[k]      = 1'b1;
    endtask

    task automatic wait_grant(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                              input bit want_resp, input logic [15:0] exp_data, input logic exp_err, input int lat);
        int n;
        logic [1:0] exp_r;
        logic [7:0] one;
        n = 0;
        exp_r = (id == 1) ? 2'b10 : 2'b01;
        one = 8'h01 << op;
        @(negedge clk_i);
        while (bus.req_ready_o == 2'b00 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL grant_timeout req=%0d", id);
            bus.req_valid_i[id] = 1'b0;
            return;
        end
        if (bus.req_ready_o !== exp_r) begin
            bad++;
            $display("FAIL grant got=%b want=%b", bus.req_ready_o, exp_r);
        end
        iq.push_back('{op, one, a, b});
        if (want_resp) rq.push_back('{id, exp_data, exp_err, lat, cyc});
        @(posedge clk_i); #1;
        bus.req_valid_i[id] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || iq.size() != 0) && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL drain_timeout rq=%0d iq=%0d want 0/0", rq.size(), iq.size());
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic check_zero(input string name);
        total++;
        if (bus.req_ready_o !== 2'b00 || bus.resp_valid_o !== 2'b00 || bus.resp_data_o !== 16'h0000 ||
            bus.resp_err_o !== 1'b0 || bus.md_valid_o !== 1'b0 || bus.md_inst_o !== 8'h00 ||
            bus.md_ra_o !== 16'h0000 || bus.md_rb_o !== 16'h0000) begin
            bad++;
            $display("FAIL %s got rdy=%b rv=%b rd=%h re=%b mv=%b mi=%h ra=%h rb=%h want all zero", name,
                     bus.req_ready_o, bus.resp_valid_o, bus.resp_data_o, bus.resp_err_o,
                     bus.md_valid_o, bus.md_inst_o, bus.md_ra_o, bus.md_rb_o);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        bus.req_valid_i = 2'b00;
        bus.req_op_i    = 6'd0;
        bus.req_ra_i    = 32'd0;
        bus.req_rb_i    = 32'd0;
        bus.md_stall_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_zero("reset_hold");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_zero("after_reset");

        // Single MUL from requester 0, unit latency 1.
        unit_lat = 1;
        @(posedge clk_i); #1;
        set_req(0, 3'd0, 16'h0003, 16'h0005);
        wait_grant(0, 3'd0, 16'h0003, 16'h0005, 1'b1, 16'h000F, 1'b0, 3);
        drain();

        // Simultaneous requests after reset, then pointer alternation.
        do_reset();
        set_req(0, 3'd5, 16'h0064, 16'h0007);
        set_req(1, 3'd7, 16'h0064, 16'h0007);
        wait_grant(0, 3'd5, 16'h0064, 16'h0007, 1'b1, 16'h000E, 1'b0, 3);
        wait_grant(1, 3'd7, 16'h0064, 16'h0007, 1'b1, 16'h0002, 1'b0, 3);
        drain();
        set_req(0, 3'd3, 16'hFFFF, 16'hFFFF);
        set_req(1, 3'd1, 16'hFFFF, 16'hFFFF);
        wait_grant(0, 3'd3, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, 1'b0, 3);
        set_req(0, 3'd2, 16'hFFFF, 16'h0002);
        wait_grant(1, 3'd1, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 3);
        wait_grant(0, 3'd2, 16'hFFFF, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 3);
        drain();

        // Division corner cases from requester 1, unit latency 3.
        unit_lat = 3;
        set_req(1, 3'd4, 16'h8000, 16'hFFFF);
        wait_grant(1, 3'd4, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 5);
        set_req(1, 3'd6, 16'hFFF9, 16'h0002);
        wait_grant(1, 3'd6, 16'hFFF9, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 5);
        set_req(1, 3'd5, 16'h1234, 16'h0000);
        wait_grant(1, 3'd5, 16'h1234, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 5);
        drain();

        // Stray md_ready in IDLE must not produce a response.
        spur_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            total++;
            if (bus.resp_valid_o !== 2'b00 || bus.md_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_spurious got rv=%b mv=%b want 00/0", bus.resp_valid_o, bus.md_valid_o);
            end
        end
        @(posedge clk_i); #1;
        spur_rdy = 1'b0;

        // Stalled issue with stray md_ready: outputs must hold until the stall drops.
        unit_lat = 2;
        bus.md_stall_i = 1'b1;
        set_req(0, 3'd4, 16'h0064, 16'hFFF9);
        wait_grant(0, 3'd4, 16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 1'b0, -1);
        spur_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            total++;
            if (bus.md_valid_o !== 1'b1 || bus.md_inst_o !== 8'h10 || bus.md_ra_o !== 16'h0064 || bus.md_rb_o !== 16'hFFF9) begin
                bad++;
                $display("FAIL stall_hold cyc%0d got mv=%b mi=%h ra=%h rb=%h want 1/10/0064/fff9",
                         i, bus.md_valid_o, bus.md_inst_o, bus.md_ra_o, bus.md_rb_o);
            end
            @(posedge clk_i); #1;
        end
        spur_rdy = 1'b0;
        bus.md_stall_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (bus.md_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_release got mv=%b want 1", bus.md_valid_o);
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        total++;
        if (bus.md_valid_o !== 1'b0 || bus.md_inst_o !== 8'h00 || bus.md_ra_o !== 16'h0064) begin
            bad++;
            $display("FAIL wait_entry got mv=%b mi=%h ra=%h want 0/00/0064", bus.md_valid_o, bus.md_inst_o, bus.md_ra_o);
        end
        drain();

        // Reset during WAIT discards the operation; the next request is served normally.
        unit_lat = 20;
        set_req(1, 3'd0, 16'h0002, 16'h0003);
        wait_grant(1, 3'd0, 16'h0002, 16'h0003, 1'b0, 16'h0000, 1'b0, -1);
        repeat (4) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check_zero("reset_in_wait");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (30) @(posedge clk_i);
        @(negedge clk_i);
        check_zero("post_reset_idle");
        unit_lat = 1;
        @(posedge clk_i); #1;
        set_req(1, 3'd6, 16'h0064, 16'h0007);
        wait_grant(1, 3'd6, 16'h0064, 16'h0007, 1'b1, 16'h0002, 1'b0, 3);
        drain();

        // Unit never answers.
        unit_hang = 1'b1;
        set_req(0, 3'd5, 16'h0010, 16'h0002);
`ifdef MULDIV_ARB_WDT_EN
        wait_grant(0, 3'd5, 16'h0010, 16'h0002, 1'b1, 16'h0000, 1'b1, 66);
        drain();
`else
        wait_grant(0, 3'd5, 16'h0010, 16'h0002, 1'b0, 16'h0000, 1'b0, -1);
        repeat (100) @(posedge clk_i);
        #1;
        set_req(0, 3'd0, 16'h0001, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            total++;
            if (bus.req_ready_o !== 2'b00 || bus.resp_valid_o !== 2'b00 || bus.md_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL wait_hold got rdy=%b rv=%b mv=%b want 00/00/0", bus.req_ready_o, bus.resp_valid_o, bus.md_valid_o);
            end
        end
        bus.req_valid_i = 2'b00;
        do_reset();
        drain();
`endif
        unit_hang = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: N, default 16, operand and result width.
REQ-003 clk_i  input  1  clock; all state changes on the rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 req_valid_i  input  2  per-requester request; bit k belongs to requester k.
REQ-006 req_op_i  input  6  3-bit op per requester; bits [3k+2:3k] belong to requester k; 0=MUL 1=MULH 2=MULHSU 3=MULHU 4=DIV 5=DIVU 6=REM 7=REMU.
REQ-007 req_ra_i  input  2N  operand A per requester; bits [kN+N-1:kN] belong to requester k.
REQ-008 req_rb_i  input  2N  operand B per requester; same packing as req_ra_i.
REQ-009 req_ready_o  output  2  one-cycle accept pulse to the granted requester.
REQ-010 resp_valid_o  output  2  one-cycle response pulse to the owning requester.
REQ-011 resp_data_o  output  N  shared result bus; valid only while a resp_valid_o bit is 1.
REQ-012 resp_err_o  output  1  watchdog error flag, qualified by resp_valid_o.
REQ-013 md_valid_o  output  1  issue strobe to the mul/div unit.
REQ-014 md_inst_o  output  8  one-hot instruction select; bit index equals op code.
REQ-015 md_ra_o, md_rb_o  output  N each  operands to the mul/div unit.
REQ-016 md_stall_i  input  1  unit busy; an issue is not taken while this is 1.
REQ-017 md_ready_i  input  1  unit result-valid pulse.
REQ-018 md_result_i  input  N  unit result.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT and RESP, with exactly one operation in flight.
REQ-020 IDLE: if any req_valid_i bit is 1, the block SHALL grant one requester, pulse its req_ready_o in the same cycle, latch its op, ra, rb and owner id, and go to ISSUE.
REQ-021 Arbitration SHALL be round-robin: a 1-bit priority pointer favours requester 0 after reset and points at the non-granted requester after every grant; a lone requester is always granted.
REQ-022 ISSUE: md_valid_o SHALL be 1 and md_inst_o SHALL be the one-hot of the latched op; if md_stall_i=0 the block goes to WAIT on the next edge, otherwise it holds ISSUE with the outputs stable.
REQ-023 WAIT: md_valid_o SHALL be 0; on md_ready_i=1 the block latches md_result_i and goes to RESP.
REQ-024 RESP: resp_valid_o[owner] SHALL be 1 for exactly one cycle with the latched data, resp_err_o=0, then the block returns to IDLE.
REQ-025 Accept-to-response latency SHALL be the unit latency plus 2 cycles, and a new grant SHALL be possible in the cycle after RESP.
REQ-026 md_inst_o SHALL be all zero and md_ra_o/md_rb_o SHALL be held at their last values outside ISSUE.
REQ-027 md_ready_i SHALL be ignored in IDLE, ISSUE and RESP.
REQ-028 Requests arriving outside IDLE SHALL NOT be accepted; req_valid_i is sampled only in IDLE.
REQ-029 At most one req_ready_o bit and at most one resp_valid_o bit SHALL be 1 in any cycle.
REQ-030 Data SHALL be passed through unmodified; no arithmetic is performed in this block.

Reset
REQ-031 Reset assertion SHALL immediately force IDLE, priority pointer=0, and all outputs to 0 (req_ready_o, resp_valid_o, resp_data_o, resp_err_o, md_valid_o, md_inst_o, md_ra_o, md_rb_o).
REQ-032 On reset mid-operation, the in-flight operation SHALL be discarded with no response; the first cycle after deassertion is IDLE.

Configuration
REQ-033 Macro MULDIV_ARB_WDT_EN defined: a 6-bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-034 With MULDIV_ARB_WDT_EN defined, if md_ready_i has not arrived when the counter reaches 63, the block SHALL enter RESP with resp_err_o=1 and resp_data_o=0.
REQ-035 With MULDIV_ARB_WDT_EN defined, md_ready_i arriving in the same cycle as expiry SHALL take precedence (normal response).
REQ-036 MULDIV_ARB_WDT_EN undefined: WAIT SHALL be held indefinitely, resp_err_o SHALL be a constant 0, and no counter SHALL be instantiated.

Verification
REQ-037 Requester 0 MUL ra=0x0003 rb=0x0005 -> req_ready_o=01, md_inst_o=0x01 in ISSUE, resp_valid_o=01 with resp_data_o=0x000F.
REQ-038 Both requesters request in the same cycle after reset (req0 DIVU 0x0064/0x0007, req1 REMU 0x0064/0x0007) -> requester 0 served first with 0x000E, then requester 1 with 0x0002, and the pointer alternates.
REQ-039 Requester 1 DIV 0x8000/0xFFFF, then REM 0xFFF9/0x0002, then DIVU 0x1234/0x0000 -> responses 0x8000, 0xFFFF, 0xFFFF.
REQ-040 md_stall_i held at 1 for 5 cycles in ISSUE -> md_valid_o and operands stable for those 5 cycles, with the transition to WAIT on the first cycle md_stall_i=0.
REQ-041 WDT enabled, md_ready_i tied to 0 -> resp_valid_o pulses with resp_err_o=1 and resp_data_o=0 at WAIT count 63; WDT disabled -> the block stays in WAIT.
REQ-042 rst_ni asserted in WAIT -> all outputs are 0 at once, no response is produced after deassertion, and the next request is served normally.
